// File: rtl/fine_delay_pkg.sv
// Shared types and tap-split helper for the three-stage fine delay controller.
package fine_delay_pkg;

  localparam int unsigned TAP_MAX = 31;
  localparam int unsigned STAGES  = 3;
  localparam int unsigned TAP_W   = 5;
  localparam int unsigned TOTAL_W = 7;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [2:0] {
    WAIT_RDY,
    IDLE,
    STEP,
    SETTLE,
    CHECK
  } state_t;

  typedef struct packed {
    logic [TAP_W-1:0] t3;
    logic [TAP_W-1:0] t2;
    logic [TAP_W-1:0] t1;
  } tap_split_t;

  // Fill stage 1 first, then stage 2, remainder to stage 3.
  function automatic tap_split_t split_taps(input logic [TOTAL_W-1:0] total);
    tap_split_t  s;
    int unsigned rem;
    int unsigned t1;
    int unsigned t2;
    rem  = 32'(total);
    t1   = (rem > TAP_MAX) ? TAP_MAX : rem;
    rem  = rem - t1;
    t2   = (rem > TAP_MAX) ? TAP_MAX : rem;
    rem  = rem - t2;
    s.t1 = TAP_W'(t1);
    s.t2 = TAP_W'(t2);
    s.t3 = TAP_W'(rem);
    return s;
  endfunction

endpackage

// File: rtl/fine_delay_ctrl.sv
// Ramps a three-stage IDELAY chain one tap per pass toward a requested total,
// verifying the stage readback after each settle window.
module fine_delay_ctrl
  import fine_delay_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned RETRY_MAX     = 3,
  parameter int unsigned MAX_TOTAL     = 93
) (
  input  logic               clk_400,
  input  logic               reset_n,
  input  logic               delay_rdy,
  input  logic               req_valid,
  input  logic [TOTAL_W-1:0] req_total,
  output logic               req_ready,
  output logic [TAP_W-1:0]   fineDelay1,
  output logic [TAP_W-1:0]   fineDelay2,
  output logic [TAP_W-1:0]   fineDelay3,
  input  logic [TAP_W-1:0]   fineDelay_data1,
  input  logic [TAP_W-1:0]   fineDelay_data2,
  input  logic [TAP_W-1:0]   fineDelay_data3,
  output logic [TOTAL_W-1:0] applied_total,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_t             state_q, state_d;
  logic [TOTAL_W-1:0] target_q, target_d;
  logic [TOTAL_W-1:0] applied_d;
  logic [CNT_W-1:0]   retry_q, retry_d;
  logic [CNT_W-1:0]   settle_q, settle_d;
  logic               done_d, err_d;
  logic               match_c;
  tap_split_t         split_d;

  assign match_c = (fineDelay_data1 == fineDelay1) &&
                   (fineDelay_data2 == fineDelay2) &&
                   (fineDelay_data3 == fineDelay3);

  assign split_d = split_taps(applied_d);

  // Next-state and next-output logic; losing delay_rdy overrides everything.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    applied_d = applied_total;
    retry_d   = retry_q;
    settle_d  = settle_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    if ((state_q != WAIT_RDY) && !delay_rdy) begin
      state_d  = WAIT_RDY;
      err_d    = busy;
      target_d = '0;
      retry_d  = '0;
    end else begin
      case (state_q)
        WAIT_RDY: begin
          if (delay_rdy) state_d = IDLE;
        end
        IDLE: begin
          if (req_valid && req_ready) begin
            if (32'(req_total) <= MAX_TOTAL) begin
              target_d = req_total;
              retry_d  = '0;
              state_d  = STEP;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        STEP: begin
          if (applied_total < target_q) begin
            applied_d = applied_total + TOTAL_W'(1);
          end else if (applied_total > target_q) begin
            applied_d = applied_total - TOTAL_W'(1);
          end
          settle_d = CNT_W'(SETTLE_CYCLES - 1);
          state_d  = SETTLE;
        end
        SETTLE: begin
          if (settle_q == '0) begin
            state_d = CHECK;
          end else begin
            settle_d = settle_q - CNT_W'(1);
          end
        end
        CHECK: begin
          if (match_c) begin
            retry_d = '0;
            if (applied_total == target_q) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = STEP;
            end
          end else if (32'(retry_q) + 32'd1 >= RETRY_MAX) begin
            retry_d = '0;
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            retry_d  = retry_q + CNT_W'(1);
            settle_d = CNT_W'(SETTLE_CYCLES - 1);
            state_d  = SETTLE;
          end
        end
        default: state_d = WAIT_RDY;
      endcase
    end
  end

  // Taps are registered straight from the split of the next total, so they never lag it.
  always_ff @(posedge clk_400) begin
    if (!reset_n) begin
      state_q       <= WAIT_RDY;
      target_q      <= '0;
      applied_total <= '0;
      retry_q       <= '0;
      settle_q      <= '0;
      fineDelay1    <= '0;
      fineDelay2    <= '0;
      fineDelay3    <= '0;
      req_ready     <= 1'b0;
      busy          <= 1'b1;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      applied_total <= applied_d;
      retry_q       <= retry_d;
      settle_q      <= settle_d;
      fineDelay1    <= split_d.t1;
      fineDelay2    <= split_d.t2;
      fineDelay3    <= split_d.t3;
      req_ready     <= (state_d == IDLE);
      busy          <= (state_d != IDLE);
      done          <= done_d;
      err           <= err_d;
    end
  end

endmodule

// File: tb/tb_fine_delay_ctrl.sv
// Directed bench for fine_delay_ctrl with a two-cycle echo model of the delay chain readback.
module tb_fine_delay_ctrl;

  logic       clk_400 = 1'b0;
  logic       reset_n = 1'b0;
  logic       delay_rdy = 1'b0;
  logic       req_valid = 1'b0;
  logic [6:0] req_total = '0;
  logic       req_ready;
  logic [4:0] fineDelay1, fineDelay2, fineDelay3;
  logic [4:0] fineDelay_data1, fineDelay_data2, fineDelay_data3;
  logic [6:0] applied_total;
  logic       busy, done, err;

  logic        stuck1 = 1'b0;
  logic [14:0] echo1 = '0;
  logic [14:0] echo2 = '0;
  int          total = 0;
  int          bad = 0;
  int          both_cnt = 0;

  fine_delay_ctrl #(.SETTLE_CYCLES(4), .RETRY_MAX(3), .MAX_TOTAL(93)) dut (
    .clk_400(clk_400), .reset_n(reset_n), .delay_rdy(delay_rdy),
    .req_valid(req_valid), .req_total(req_total), .req_ready(req_ready),
    .fineDelay1(fineDelay1), .fineDelay2(fineDelay2), .fineDelay3(fineDelay3),
    .fineDelay_data1(fineDelay_data1), .fineDelay_data2(fineDelay_data2),
    .fineDelay_data3(fineDelay_data3), .applied_total(applied_total),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk_400 = ~clk_400;

  always @(posedge clk_400) begin
    echo1 <= {fineDelay3, fineDelay2, fineDelay1};
    echo2 <= echo1;
  end
  assign fineDelay_data1 = stuck1 ? 5'd0 : echo2[4:0];
  assign fineDelay_data2 = echo2[9:5];
  assign fineDelay_data3 = echo2[14:10];

  always @(negedge clk_400) if (done && err) both_cnt++;

  task automatic tick();
    @(posedge clk_400);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_taps(input string tag, input int t1, input int t2, input int t3);
    chk({tag, "_t1"}, 32'(fineDelay1), 32'(t1));
    chk({tag, "_t2"}, 32'(fineDelay2), 32'(t2));
    chk({tag, "_t3"}, 32'(fineDelay3), 32'(t3));
  endtask

  initial begin
    int n;
    int viol;
    int nchg;
    int errs;
    int dones;
    logic [4:0] p1, p2, p3;

    repeat (3) tick();
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_applied", 32'(applied_total), 0);
    chk_taps("rst", 0, 0, 0);

    // Leave reset, then raise delay_rdy; IDLE follows one edge later.
    reset_n = 1'b1;
    repeat (2) tick();
    chk("wait_ready_low", 32'(req_ready), 0);
    delay_rdy = 1'b1;
    chk("rdy_not_yet", 32'(req_ready), 0);
    tick();
    chk("rdy_ready", 32'(req_ready), 1);
    chk("rdy_busy", 32'(busy), 0);

    // Ramp 0 -> 40: 40 passes of 6 cycles.
    req_total = 7'd40; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("r40_busy", 32'(busy), 1);
    n = 0; viol = 0;
    p1 = fineDelay1; p2 = fineDelay2; p3 = fineDelay3;
    while (!done && n < 400) begin
      tick();
      n++;
      nchg = 0;
      if (fineDelay1 != p1) begin nchg++; if (fineDelay1 != p1 + 5'd1) viol++; end
      if (fineDelay2 != p2) begin nchg++; if (fineDelay2 != p2 + 5'd1) viol++; end
      if (fineDelay3 != p3) begin nchg++; if (fineDelay3 != p3 + 5'd1) viol++; end
      if (nchg > 1) viol++;
      p1 = fineDelay1; p2 = fineDelay2; p3 = fineDelay3;
    end
    chk("r40_latency", 32'(n), 240);
    chk("r40_one_stage", 32'(viol), 0);
    chk("r40_applied", 32'(applied_total), 40);
    chk_taps("r40", 31, 9, 0);
    chk("r40_ready", 32'(req_ready), 1);
    tick();
    chk("r40_done_pulse", 32'(done), 0);

    // Out-of-range request is rejected without leaving IDLE.
    req_total = 7'd94; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("rej_err", 32'(err), 1);
    chk("rej_busy", 32'(busy), 0);
    chk("rej_applied", 32'(applied_total), 40);
    chk_taps("rej", 31, 9, 0);
    tick();
    chk("rej_err_pulse", 32'(err), 0);
    chk("rej_busy2", 32'(busy), 0);

    // Request equal to current total: one pass.
    req_total = 7'd40; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!done && n < 100) begin tick(); n++; end
    chk("eq_latency", 32'(n), 6);
    chk("eq_applied", 32'(applied_total), 40);
    chk_taps("eq", 31, 9, 0);

    // Ramp down, then reset mid-ramp.
    tick();
    req_total = 7'd0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (50) tick();
    chk("dn_applied", 32'(applied_total), 31);
    chk_taps("dn", 31, 0, 0);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_applied", 32'(applied_total), 0);
    chk_taps("mid_rst", 0, 0, 0);
    chk("mid_rst_busy", 32'(busy), 1);
    chk("mid_rst_ready", 32'(req_ready), 0);
    reset_n = 1'b1;
    repeat (2) tick();
    chk("mid_rst_back", 32'(req_ready), 1);

    // Stage-1 readback stuck at zero: three mismatches then abort.
    stuck1 = 1'b1;
    req_total = 7'd1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 0; dones = 0;
    while (!err && n < 200) begin tick(); n++; if (done) dones++; end
    chk("stk_latency", 32'(n), 16);
    chk("stk_done", 32'(dones), 0);
    chk("stk_applied", 32'(applied_total), 1);
    chk_taps("stk", 1, 0, 0);
    chk("stk_ready", 32'(req_ready), 1);
    stuck1 = 1'b0;
    tick();

    // Back to zero, then ramp to 20 and drop delay_rdy during pass 10.
    req_total = 7'd0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!done && n < 100) begin tick(); n++; end
    chk("z_latency", 32'(n), 6);
    chk("z_applied", 32'(applied_total), 0);
    req_total = 7'd20; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (10) tick();
    req_total = 7'd5; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (45) tick();
    chk("drop_pre_applied", 32'(applied_total), 10);
    delay_rdy = 1'b0;
    tick();
    chk("drop_err", 32'(err), 1);
    chk("drop_busy", 32'(busy), 1);
    chk("drop_ready", 32'(req_ready), 0);
    chk("drop_applied", 32'(applied_total), 10);
    chk_taps("drop", 10, 0, 0);
    repeat (3) tick();
    chk("drop_err_pulse", 32'(err), 0);
    chk("drop_stay_wait", 32'(req_ready), 0);
    chk("drop_held", 32'(applied_total), 10);
    delay_rdy = 1'b1;
    tick();
    chk("drop_recover", 32'(req_ready), 1);

    // Target was discarded: a fresh request from 10 to 12 takes two passes.
    req_total = 7'd12; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 0; errs = 0;
    while (!done && n < 100) begin tick(); n++; if (err) errs++; end
    chk("fin_latency", 32'(n), 12);
    chk("fin_err", 32'(errs), 0);
    chk("fin_applied", 32'(applied_total), 12);
    chk_taps("fin", 12, 0, 0);
    tick();
    chk("done_err_overlap", 32'(both_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
